bus_responder: RTL and testbench
================================

# bus_responder

Target-side responder for the 6502 core bus: the block answers every `rd`/`we` access the core issues and throttles the core through `ce` for a fixed number of wait states. It decodes the 16-bit address into mirrored on-chip RAM, a board I/O page (LED latch, debounced keys with press flags, tick counter) and hard-wired interrupt/reset vectors. It sits between the core and the board pins in the MAX II top level.

## Interface
- `RAM_AW`, 9: RAM address width; RAM size is 2^RAM_AW bytes.
- `WAIT`, 1: wait states per access. Legal range is 1..15; 0 is illegal.
- `DEB_W`, 16: width of the debounce prescaler; keys are sampled every 2^DEB_W clocks.
- `VECTOR`, 16'h0000: value returned for the NMI, reset and IRQ vectors.
- `clock` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `address` input 16: core address.
- `out` input 8: core write data.
- `rd` input 1: core read request.
- `we` input 1: core write request.
- `ce` output 1: core clock enable; 0 stalls the core.
- `in` output 8: read data to the core.
- `key` input 4: raw board keys, active-low, asynchronous.
- `led` output 8: LED latch.

## Operation
- Address map:
  - $D000: LED register, R/W.
  - $D001: KEY register, read-only. Bits [3:0] are the debounced key levels; bits [7:4] are the press flags.
  - $D002: TICK, the free-running 8-bit counter. Reads return its value; a write clears it to 0.
  - $D003–$DFFF: unmapped. Reads return $FF; writes are ignored.
  - $FFFA–$FFFF: vectors. Even addresses return `VECTOR[7:0]`, odd addresses return `VECTOR[15:8]`. Writes are ignored.
  - All other addresses: RAM at `address[RAM_AW-1:0]`, mirrored.
- Access FSM has three states:
  - IDLE: the next state is BUSY if `rd|we`, with the wait counter loaded to `WAIT-1`.
  - BUSY: the counter decrements; the next state is ACK when it reaches 0.
  - ACK: the next state is IDLE.
- `ce` is combinational: `ce = ~(rd|we) | (state==ACK)`.
- `address`, `out`, `rd` and `we` are captured in the first cycle of the access (T0). Changes to them while in BUSY are ignored.
- `rd` and `we` both high is treated as a write, and `in` returns $FF.
- Writes commit on the rising edge that ends the ACK cycle.
- Read data is registered during BUSY and is stable on `in` throughout ACK. Outside ACK, `in` holds its last value.
- Key path:
  - A 2-FF synchronizer feeds the sampler.
  - On each prescaler tick the raw sample is compared with the previous sample. A key's debounced bit updates only if the two samples match.
  - A debounced 1→0 transition sets the corresponding press flag.
- Press flags clear when a $D001 read is acknowledged. If a new press edge lands in the same cycle as the clearing read, the flag stays set: set wins.
- TICK increments every clock and wraps from $FF to $00. If a write of $D002 commits in the same cycle, the write wins and TICK becomes 0.

## Timing
- Access begins at T0, the first cycle with `rd|we` high.
- `ce`=0 during T0..T0+WAIT-1 and `ce`=1 at T0+WAIT (ACK).
- Total access length is WAIT+1 cycles. With WAIT=1, `ce` reads 0,1.
- Back-to-back accesses: the cycle after ACK with `rd|we` high is a new T0.
- Reset values:
  - Internal: state IDLE, counter 0, press flags 0, debounced keys 4'hF, prescaler 0, TICK 0.
  - Outputs: `led` 8'h00, `in` 8'hFF. `ce` follows its equation, so it is 0 if `rd|we` is high during or after reset.
- Reset mid-access aborts the access: no write commits and the FSM returns to IDLE. RAM contents are not reset.
- A key press is reflected in KEY no sooner than 2 sync cycles plus 2 prescaler ticks after the press, and no later than 2 sync cycles plus 3 ticks.

## Structure
- Package `bus_pkg` holds:
  - Address constants: `A_LED`, `A_KEY`, `A_TICK`, the I/O page base $D000, and the vector base $FFFA.
  - The FSM state enum: IDLE, BUSY, ACK.
- Sub-module `key_debounce` contains the synchronizer, prescaler, sample comparison, debounced levels and press flags. It has a `clr` input to clear the flags.
- RAM is inferred as a synchronous single-port array with a registered read.

## Test plan
- WAIT=1: read RAM $0010 after writing $5A there → `ce` sequence 0,1 on each access; `in`=$5A in the read's ACK cycle. A read of $0210 (mirror) also returns $5A.
- WAIT=3: write $A5 to $D000 → `ce` sequence 0,0,0,1; `led` becomes $A5 on the edge ending ACK. A read of $D000 returns $A5.
- Vectors: VECTOR=16'h1234 → read $FFFC returns $34, read $FFFD returns $12. A write to $FFFC is ignored. A read of $D005 returns $FF.
- Keys, DEB_W=4: pulse key[1] low for 8 clocks → no change in KEY. Hold key[1] low for 64 clocks → KEY reads $2D. A second read returns $0D.
- Clear/set race: a press edge on the same cycle as a $D001 read ACK → bit 5 remains set on the next read.
- Reset asserted during BUSY of a write to $D000 → `led` stays $00. `in`=$FF and `ce` follows `rd|we`. The next access completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared address map and access-FSM state type for the 6502 bus responder.
package bus_pkg;

   localparam logic [15:0] A_IO_BASE  = 16'hD000;
   localparam logic [15:0] A_LED      = 16'hD000;
   localparam logic [15:0] A_KEY      = 16'hD001;
   localparam logic [15:0] A_TICK     = 16'hD002;
   localparam logic [15:0] A_VEC_BASE = 16'hFFFA;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      ACK
   } state_t;

endpackage

// File: rtl/key_debounce.sv
// Key synchronizer and prescaled two-sample debouncer with sticky press flags.
module key_debounce
   import bus_pkg::*;
#(
   parameter int unsigned DEB_W = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] key,
   input  logic       clr,
   output logic [3:0] level,
   output logic [3:0] flags
);

   logic [3:0]       sync1_q, sync2_q, samp_q;
   logic [3:0]       level_q, level_d;
   logic [3:0]       flags_q, flags_d;
   logic [3:0]       match;
   logic [DEB_W-1:0] pre_q;
   logic             tick;

   assign tick  = &pre_q;
   assign match = ~(sync2_q ^ samp_q);

   always_comb begin
      level_d = level_q;
      if (tick) begin
         level_d = (match & sync2_q) | (~match & level_q);
      end
      // A press edge in the same cycle as a clearing read keeps the flag set.
      flags_d = (clr ? 4'h0 : flags_q) | (level_q & ~level_d);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= 4'hF;
         sync2_q <= 4'hF;
         samp_q  <= 4'hF;
         level_q <= 4'hF;
         flags_q <= 4'h0;
         pre_q   <= '0;
      end else begin
         sync1_q <= key;
         sync2_q <= sync1_q;
         pre_q   <= pre_q + 1'b1;
         if (tick) begin
            samp_q <= sync2_q;
         end
         level_q <= level_d;
         flags_q <= flags_d;
      end
   end

   assign level = level_q;
   assign flags = flags_q;

endmodule

// File: rtl/bus_responder.sv
// Target-side responder for the 6502 core bus: wait-state FSM, mirrored RAM,
// board I/O page (LED, keys, tick) and fixed vectors.
module bus_responder
   import bus_pkg::*;
#(
   parameter int unsigned RAM_AW = 9,
   parameter int unsigned WAIT   = 1,
   parameter int unsigned DEB_W  = 16,
   parameter logic [15:0] VECTOR = 16'h0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic [7:0]  out,
   input  logic        rd,
   input  logic        we,
   output logic        ce,
   output logic [7:0]  in,
   input  logic [3:0]  key,
   output logic [7:0]  led
);

   localparam logic [3:0] WAIT_M1 = 4'(WAIT - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [15:0]       addr_q;
   logic [7:0]        data_q;
   logic              wr_q;
   logic [7:0]        led_q, tick_q, in_q, rdata, ram_rd_q;
   logic [3:0]        key_level, key_flags;
   logic              commit, is_vec, is_io, is_ram, key_clr;
   logic [RAM_AW-1:0] ram_addr;
   logic [7:0]        mem [0:(1 << RAM_AW) - 1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (rd | we) begin
               cnt_d   = WAIT_M1;
               // T0 itself is the first wait state, so WAIT=1 goes straight to ACK.
               state_d = (WAIT_M1 == 4'd0) ? ACK : BUSY;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_d == 4'd0) begin
               state_d = ACK;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 16'h0000;
         data_q  <= 8'h00;
         wr_q    <= 1'b0;
         led_q   <= 8'h00;
         tick_q  <= 8'h00;
         in_q    <= 8'hFF;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == IDLE && (rd | we)) begin
            addr_q <= address;
            data_q <= out;
            wr_q   <= we;
         end
         if (commit && addr_q == A_LED) begin
            led_q <= data_q;
         end
         tick_q <= (commit && addr_q == A_TICK) ? 8'h00 : tick_q + 8'd1;
         if (state_q == ACK) begin
            in_q <= rdata;
         end
      end
   end

   assign commit  = (state_q == ACK) && wr_q;
   assign key_clr = (state_q == ACK) && !wr_q && (addr_q == A_KEY);
   assign is_vec  = addr_q >= A_VEC_BASE;
   assign is_io   = addr_q[15:12] == A_IO_BASE[15:12];
   assign is_ram  = !is_vec && !is_io;

   // RAM tracks the live address at T0 so WAIT=1 reads are ready by ACK.
   assign ram_addr = (state_q == IDLE) ? address[RAM_AW-1:0] : addr_q[RAM_AW-1:0];

   always_ff @(posedge clock) begin
      if (commit && is_ram) begin
         mem[addr_q[RAM_AW-1:0]] <= data_q;
      end
      ram_rd_q <= mem[ram_addr];
   end

   always_comb begin
      rdata = 8'hFF;
      if (!wr_q) begin
         if (is_vec) begin
            rdata = addr_q[0] ? VECTOR[15:8] : VECTOR[7:0];
         end else if (is_io) begin
            if (addr_q == A_LED) begin
               rdata = led_q;
            end else if (addr_q == A_KEY) begin
               rdata = {key_flags, key_level};
            end else if (addr_q == A_TICK) begin
               rdata = tick_q;
            end
         end else begin
            rdata = ram_rd_q;
         end
      end
   end

   key_debounce #(
      .DEB_W(DEB_W)
   ) u_key_debounce (
      .clock(clock),
      .reset(reset),
      .key  (key),
      .clr  (key_clr),
      .level(key_level),
      .flags(key_flags)
   );

   assign ce  = ~(rd | we) | (state_q == ACK);
   assign in  = (state_q == ACK) ? rdata : in_q;
   assign led = led_q;

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench: two responders (WAIT=1 and WAIT=3) driven by a small bus model.
module tb_bus_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] address [2];
   logic [7:0]  wdata   [2];
   logic        rd      [2];
   logic        we      [2];
   logic        ce      [2];
   logic [7:0]  rdat    [2];
   logic [7:0]  led     [2];
   logic [3:0]  key0;
   logic [3:0]  key1;

   int n_checks = 0;
   int n_errors = 0;
   int cyc;

   typedef struct {
      string      tag;
      logic [7:0] data;
      logic       chk;
      int         ncyc;
   } exp_t;

   exp_t sb[$];

   always #5 clock = ~clock;

   always @(posedge clock or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   bus_responder #(
      .RAM_AW(9), .WAIT(1), .DEB_W(4), .VECTOR(16'h1234)
   ) u_dut0 (
      .clock(clock), .reset(reset), .address(address[0]), .out(wdata[0]),
      .rd(rd[0]), .we(we[0]), .ce(ce[0]), .in(rdat[0]), .key(key0), .led(led[0])
   );

   bus_responder #(
      .RAM_AW(9), .WAIT(3), .DEB_W(4), .VECTOR(16'h0000)
   ) u_dut1 (
      .clock(clock), .reset(reset), .address(address[1]), .out(wdata[1]),
      .rd(rd[1]), .we(we[1]), .ce(ce[1]), .in(rdat[1]), .key(key1), .led(led[1])
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // One bus access; leaves rd/we asserted so a following call is back-to-back.
   task automatic access(input string tag, input int s, input logic r, input logic w,
                         input logic [15:0] a, input logic [7:0] d, input logic chk,
                         input logic [7:0] exp, output logic [7:0] got);
      exp_t e;
      int   n;
      bit   done;
      @(posedge clock);
      #1;
      address[s] = a;
      wdata[s]   = d;
      rd[s]      = r;
      we[s]      = w;
      e.tag  = tag;
      e.data = exp;
      e.chk  = chk;
      e.ncyc = (s == 0) ? 2 : 4;
      sb.push_back(e);
      n    = 0;
      done = 1'b0;
      got  = 8'hxx;
      while (!done && n < 32) begin
         @(negedge clock);
         n++;
         if (ce[s]) begin
            done = 1'b1;
            got  = rdat[s];
         end
      end
      e = sb.pop_front();
      check({e.tag, "_len"}, 16'(n), 16'(e.ncyc));
      if (e.chk) check(e.tag, 16'(got), 16'(e.data));
   endtask

   task automatic rd_acc(input string tag, input int s, input logic [15:0] a,
                         input logic [7:0] exp);
      logic [7:0] g;
      access(tag, s, 1'b1, 1'b0, a, 8'h00, 1'b1, exp, g);
   endtask

   task automatic wr_acc(input string tag, input int s, input logic [15:0] a,
                         input logic [7:0] d);
      logic [7:0] g;
      access(tag, s, 1'b0, 1'b1, a, d, 1'b0, 8'h00, g);
   endtask

   task automatic idle(input int s);
      @(posedge clock);
      #1;
      rd[s] = 1'b0;
      we[s] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] t1, t2, g, ex;
      int         k0, k2, e_edge;

      for (int i = 0; i < 2; i++) begin
         address[i] = 16'h0000;
         wdata[i]   = 8'h00;
         rd[i]      = 1'b0;
         we[i]      = 1'b0;
      end
      key0  = 4'hF;
      key1  = 4'hF;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("rst_led0", 16'(led[0]), 16'h00);
      check("rst_in0", 16'(rdat[0]), 16'hFF);
      check("rst_in1", 16'(rdat[1]), 16'hFF);
      check("rst_ce1_idle", 16'(ce[1]), 16'h1);
      rd[0] = 1'b1;
      #1;
      check("rst_ce0_rd", 16'(ce[0]), 16'h0);
      rd[0] = 1'b0;
      @(negedge clock);
      reset = 1'b0;

      // RAM, mirror and rd&we-as-write on the WAIT=1 responder.
      wr_acc("ram_wr", 0, 16'h0010, 8'h5A);
      rd_acc("ram_rd", 0, 16'h0010, 8'h5A);
      rd_acc("ram_mirror", 0, 16'h0210, 8'h5A);
      access("rdwe_in", 0, 1'b1, 1'b1, 16'h0010, 8'h99, 1'b1, 8'hFF, g);
      rd_acc("rdwe_rd", 0, 16'h0010, 8'h99);
      idle(0);

      // Vectors and unmapped I/O.
      rd_acc("vec_lo", 0, 16'hFFFC, 8'h34);
      rd_acc("vec_hi", 0, 16'hFFFD, 8'h12);
      wr_acc("vec_wr", 0, 16'hFFFC, 8'h77);
      rd_acc("vec_lo2", 0, 16'hFFFC, 8'h34);
      rd_acc("unmapped", 0, 16'hD005, 8'hFF);
      wr_acc("below_vec_wr", 0, 16'hFFF9, 8'hC3);
      rd_acc("below_vec_rd", 0, 16'h01F9, 8'hC3);
      idle(0);

      // TICK: clear by write, then two back-to-back reads two cycles apart.
      wr_acc("tick_wr", 0, 16'hD002, 8'h55);
      access("tick_rd1", 0, 1'b1, 1'b0, 16'hD002, 8'h00, 1'b0, 8'h00, t1);
      access("tick_rd2", 0, 1'b1, 1'b0, 16'hD002, 8'h00, 1'b0, 8'h00, t2);
      idle(0);
      check("tick_cleared", 16'(t1 <= 8'd2), 16'h1);
      check("tick_delta", 16'(8'(t2 - t1)), 16'h2);

      // WAIT=3 LED write, commit on the edge ending ACK.
      wr_acc("led_wr", 1, 16'hD000, 8'hA5);
      check("led_before_commit", 16'(led[1]), 16'h00);
      idle(1);
      check("led_after_commit", 16'(led[1]), 16'hA5);
      rd_acc("led_rd", 1, 16'hD000, 8'hA5);
      idle(1);

      // Keys: short pulse is filtered, long press sets level and flag.
      rd_acc("key_init", 0, 16'hD001, 8'h0F);
      idle(0);
      key0[1] = 1'b0;
      repeat (8) @(posedge clock);
      #1;
      key0[1] = 1'b1;
      repeat (40) @(posedge clock);
      rd_acc("key_pulse", 0, 16'hD001, 8'h0F);
      idle(0);
      key0 = 4'b1101;
      repeat (64) @(posedge clock);
      rd_acc("key_press", 0, 16'hD001, 8'h2D);
      rd_acc("key_clr", 0, 16'hD001, 8'h0D);
      idle(0);
      key0 = 4'hF;
      repeat (64) @(posedge clock);
      rd_acc("key_release", 0, 16'hD001, 8'h0F);
      idle(0);

      // Clear/set race: back-to-back reads whose ACK edges land on every even edge;
      // the level falls on the second prescaler tick after the synchronizer sees it.
      @(posedge clock);
      #1;
      key0 = 4'b1101;
      k0   = cyc;
      k2   = ((k0 + 3 + 15) / 16) * 16 + 16;
      while (cyc[0] != 1'b1) @(negedge clock);
      e_edge = cyc + 3;
      while (e_edge <= k2 + 4) begin
         if (e_edge <= k2)          ex = 8'h0F;
         else if (e_edge == k2 + 2) ex = 8'h2D;
         else                       ex = 8'h0D;
         rd_acc("key_race", 0, 16'hD001, ex);
         e_edge = cyc + 3;
      end
      idle(0);
      key0 = 4'hF;

      // Reset during BUSY of an LED write aborts it.
      @(posedge clock);
      #1;
      address[1] = 16'hD000;
      wdata[1]   = 8'h3C;
      we[1]      = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      check("rstmid_led", 16'(led[1]), 16'h00);
      check("rstmid_in", 16'(rdat[1]), 16'hFF);
      check("rstmid_ce_we", 16'(ce[1]), 16'h0);
      we[1] = 1'b0;
      #1;
      check("rstmid_ce_idle", 16'(ce[1]), 16'h1);
      @(negedge clock);
      reset = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      check("rstmid_no_commit", 16'(led[1]), 16'h00);
      wr_acc("post_rst_wr", 1, 16'hD000, 8'h3C);
      idle(1);
      check("post_rst_led", 16'(led[1]), 16'h3C);
      rd_acc("post_rst_rd", 1, 16'hD000, 8'h3C);
      idle(1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
